// File: rtl/gerenciador_ativos_fila.sv
// Active-node manager: grants/refreshes nodes by address, queues misses in a small FIFO, drains it when a node frees up.
// Latency: 1 cycle, every output is registered and reflects the inputs sampled on the previous edge.
// Backpressure: no stall; a miss arriving with the FIFO full and no same-cycle pop is dropped with a descartado_out pulse.
module gerenciador_ativos_fila #(
  parameter int NUM_NA     = 8,
  parameter int ADR_WIDTH  = 5,
  parameter int FILA_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          atualizar_in,
  input  logic                          desativar_in,
  input  logic [ADR_WIDTH-1:0]          endereco_in,
  input  logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_in,
  input  logic [NUM_NA-1:0]             na_ativo_in,
  output logic [NUM_NA-1:0]             habilitar_out,
  output logic [NUM_NA-1:0]             desabilitar_out,
  output logic [$clog2(NUM_NA+1)-1:0]   ocupados_out,
  output logic                          fila_vazia_out,
  output logic                          fila_cheia_out,
  output logic                          descartado_out,
  // Address the enabled node must take on; valid alongside habilitar_out, zero otherwise.
  output logic [ADR_WIDTH-1:0]          endereco_out
);

  localparam int CW = $clog2(NUM_NA + 1);
  localparam int PW = $clog2(FILA_DEPTH);
  localparam int QW = $clog2(FILA_DEPTH + 1);

  // Isolates the lowest set bit, which gives the lowest-index priority everywhere.
  function automatic logic [NUM_NA-1:0] menor_indice(input logic [NUM_NA-1:0] v);
    return v & (~v + NUM_NA'(1));
  endfunction

  logic [ADR_WIDTH-1:0] fila_mem_q [FILA_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]        cnt_q, cnt_d;
  logic [NUM_NA-1:0]    reserva_q, reserva_d;

  logic [NUM_NA-1:0]    hab_q, hab_d, des_q, des_d;
  logic [CW-1:0]        ocup_q, ocup_d;
  logic                 vazia_q, cheia_q, descarte_q, descarte_d;
  logic [ADR_WIDTH-1:0] end_q, end_d;

  logic [NUM_NA-1:0]    hit_vec, desat_vec, livre_vec, ocupado_vec;
  logic                 atu, hit, miss, fila_vazia, fila_cheia;
  logic                 pop, direto, push;

  // Per-node address matches and free-node vector.
  always_comb begin
    hit_vec   = '0;
    desat_vec = '0;
    livre_vec = '0;
    for (int i = 0; i < NUM_NA; i++) begin
      if (na_endereco_in[ADR_WIDTH*i +: ADR_WIDTH] == endereco_in) begin
        hit_vec[i]   = na_ativo_in[i];
        desat_vec[i] = na_ativo_in[i] | reserva_q[i];
      end
      livre_vec[i] = !na_ativo_in[i] && !reserva_q[i];
    end
  end

  // Request arbitration: refresh hit beats FIFO drain, which beats a fresh miss.
  always_comb begin
    atu        = atualizar_in && !desativar_in;
    hit        = atu && (|hit_vec);
    miss       = atu && !(|hit_vec);
    fila_vazia = (cnt_q == '0);
    fila_cheia = (cnt_q == QW'(FILA_DEPTH));
    pop        = !fila_vazia && (|livre_vec) && !hit;
    // A miss is granted directly only when nothing is queued ahead of it.
    direto     = miss && fila_vazia && (|livre_vec);
    push       = miss && !direto && (!fila_cheia || pop);
    descarte_d = miss && !direto && fila_cheia && !pop;

    hab_d = '0;
    end_d = '0;
    if (hit) begin
      hab_d = menor_indice(hit_vec);
      end_d = endereco_in;
    end else if (pop) begin
      hab_d = menor_indice(livre_vec);
      end_d = fila_mem_q[rd_ptr_q];
    end else if (direto) begin
      hab_d = menor_indice(livre_vec);
      end_d = endereco_in;
    end

    des_d = desativar_in ? menor_indice(desat_vec) : '0;

    // A grant always targets a free node, so set and clear never collide on one bit.
    reserva_d = (reserva_q & ~na_ativo_in & ~des_d) | (hit ? '0 : hab_d);

    cnt_d    = cnt_q + QW'(push) - QW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    ocupado_vec = na_ativo_in | reserva_d;
    ocup_d      = '0;
    for (int i = 0; i < NUM_NA; i++) begin
      ocup_d = ocup_d + CW'(ocupado_vec[i]);
    end
  end

  // Control state and registered outputs; reset wipes queue and reservations at once.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      reserva_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hab_q      <= '0;
      des_q      <= '0;
      ocup_q     <= '0;
      vazia_q    <= 1'b1;
      cheia_q    <= 1'b0;
      descarte_q <= 1'b0;
      end_q      <= '0;
    end else begin
      reserva_q  <= reserva_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      hab_q      <= hab_d;
      des_q      <= des_d;
      ocup_q     <= ocup_d;
      vazia_q    <= (cnt_d == '0);
      cheia_q    <= (cnt_d == QW'(FILA_DEPTH));
      descarte_q <= descarte_d;
      end_q      <= end_d;
    end
  end

  // Queue storage; stale contents are harmless because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fila_mem_q[wr_ptr_q] <= endereco_in;
    end
  end

  assign habilitar_out   = hab_q;
  assign desabilitar_out = des_q;
  assign ocupados_out    = ocup_q;
  assign fila_vazia_out  = vazia_q;
  assign fila_cheia_out  = cheia_q;
  assign descartado_out  = descarte_q;
  assign endereco_out    = end_q;

endmodule

// File: tb/tb_gerenciador_ativos_fila.sv
// Bench for gerenciador_ativos_fila: directed scenarios then random traffic against a queue-based model.
// Expected outputs are pushed per cycle; a monitor pops and compares one cycle later.
// Node behaviour (activation after grant, random drop-out) is emulated by the bench.
module tb_gerenciador_ativos_fila;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int D  = 2;

  logic            clk;
  logic            rst_n;
  logic            atualizar_in, desativar_in;
  logic [AW-1:0]   endereco_in;
  logic [AW*N-1:0] na_endereco_in;
  logic [N-1:0]    na_ativo_in;
  logic [N-1:0]    habilitar_out, desabilitar_out;
  logic [2:0]      ocupados_out;
  logic            fila_vazia_out, fila_cheia_out, descartado_out;
  logic [AW-1:0]   endereco_out;

  gerenciador_ativos_fila #(.NUM_NA(N), .ADR_WIDTH(AW), .FILA_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .atualizar_in(atualizar_in), .desativar_in(desativar_in), .endereco_in(endereco_in),
    .na_endereco_in(na_endereco_in), .na_ativo_in(na_ativo_in),
    .habilitar_out(habilitar_out), .desabilitar_out(desabilitar_out),
    .ocupados_out(ocupados_out), .fila_vazia_out(fila_vazia_out),
    .fila_cheia_out(fila_cheia_out), .descartado_out(descartado_out),
    .endereco_out(endereco_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  hab;
    logic [N-1:0]  des;
    logic          drop;
    logic [2:0]    occ;
    logic          vazia;
    logic          cheia;
    logic [AW-1:0] adr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference state: queued addresses, reservation flags, and the emulated nodes.
  int          m_fila[$];
  bit [N-1:0]  m_res;
  bit [N-1:0]  env_act;
  logic [AW-1:0] env_addr [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // One cycle of the rules, applied to the inputs just driven.
  task automatic model_step(input bit r);
    exp_t e;
    int   hit, dz, fr, g, cnt;
    bit   atu;
    e = '0;
    if (r) begin
      m_res = '0;
      m_fila.delete();
      e.vazia = 1'b1;
      exp_q.push_back(e);
      return;
    end
    atu = atualizar_in && !desativar_in;
    hit = -1; dz = -1; fr = -1;
    for (int i = 0; i < N; i++) begin
      if (hit < 0 && atu && env_act[i] && env_addr[i] == endereco_in) hit = i;
      if (dz < 0 && desativar_in && (env_act[i] || m_res[i]) && env_addr[i] == endereco_in) dz = i;
      if (fr < 0 && !env_act[i] && !m_res[i]) fr = i;
    end
    if (dz >= 0) begin
      e.des[dz] = 1'b1;
      m_res[dz] = 1'b0;
    end
    if (hit >= 0) begin
      e.hab[hit] = 1'b1;
      e.adr      = endereco_in;
    end else if (m_fila.size() > 0 && fr >= 0) begin
      g = m_fila.pop_front();
      e.hab[fr] = 1'b1; e.adr = AW'(g); m_res[fr] = 1'b1; env_addr[fr] = AW'(g);
      if (atu) m_fila.push_back(int'(endereco_in));
    end else if (atu) begin
      if (m_fila.size() == 0 && fr >= 0) begin
        e.hab[fr] = 1'b1; e.adr = endereco_in; m_res[fr] = 1'b1; env_addr[fr] = endereco_in;
      end else if (m_fila.size() < D) begin
        m_fila.push_back(int'(endereco_in));
      end else begin
        e.drop = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) if (env_act[i]) m_res[i] = 1'b0;
    cnt = 0;
    for (int i = 0; i < N; i++) if (env_act[i] || m_res[i]) cnt++;
    e.occ   = 3'(cnt);
    e.vazia = (m_fila.size() == 0);
    e.cheia = (m_fila.size() == D);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit a, input bit d, input logic [AW-1:0] ad);
    @(negedge clk);
    rst_n        = r;
    atualizar_in = r ? 1'b0 : a;
    desativar_in = r ? 1'b0 : d;
    endereco_in  = ad;
    na_ativo_in  = env_act;
    for (int i = 0; i < N; i++) na_endereco_in[AW*i +: AW] = env_addr[i];
    model_step(r);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every registered output one cycle after its stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("habilitar",   32'(habilitar_out),   32'(e.hab));
        chk("desabilitar", 32'(desabilitar_out), 32'(e.des));
        chk("descartado",  32'(descartado_out),  32'(e.drop));
        chk("ocupados",    32'(ocupados_out),    32'(e.occ));
        chk("fila_vazia",  32'(fila_vazia_out),  32'(e.vazia));
        chk("fila_cheia",  32'(fila_cheia_out),  32'(e.cheia));
        chk("endereco",    32'(endereco_out),    32'(e.adr));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bit r, a, d;
    rst_n = 1'b1; atualizar_in = 1'b0; desativar_in = 1'b0; endereco_in = '0;
    na_ativo_in = '0; na_endereco_in = '0;
    env_act = '0; m_res = '0;
    for (int i = 0; i < N; i++) env_addr[i] = '0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    after_edge();
    chk("reset_vazia", 32'(fila_vazia_out), 32'd1);
    chk("reset_ocup",  32'(ocupados_out),   32'd0);

    // Idle nodes: a miss is granted to node 0.
    cyc(0, 1, 0, 5'd5);
    after_edge();
    chk("grant_first_hab",  32'(habilitar_out), 32'h1);
    chk("grant_first_ocup", 32'(ocupados_out),  32'd1);
    env_act[0] = 1'b1;
    cyc(0, 0, 0, 0);

    // Refresh of an active node.
    cyc(0, 1, 0, 5'd5);
    after_edge();
    chk("refresh_hab",   32'(habilitar_out),  32'h1);
    chk("refresh_ocup",  32'(ocupados_out),   32'd1);
    chk("refresh_vazia", 32'(fila_vazia_out), 32'd1);

    // Fill every node, then overflow the queue.
    env_act[1] = 1'b1; env_addr[1] = 5'd7;
    env_act[2] = 1'b1; env_addr[2] = 5'd3;
    env_act[3] = 1'b1; env_addr[3] = 5'd4;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 5'd9);
    cyc(0, 1, 0, 5'd11);
    after_edge();
    chk("queue_full", 32'(fila_cheia_out), 32'd1);
    chk("queue_nodrop", 32'(descartado_out), 32'd0);
    cyc(0, 1, 0, 5'd13);
    after_edge();
    chk("overflow_drop", 32'(descartado_out), 32'd1);

    // Node 2 drops out: queue head (9) goes to it.
    env_act[2] = 1'b0;
    cyc(0, 0, 0, 0);
    after_edge();
    chk("drain_hab",   32'(habilitar_out),  32'h4);
    chk("drain_addr",  32'(endereco_out),   32'd9);
    chk("drain_cheia", 32'(fila_cheia_out), 32'd0);
    env_act[2] = 1'b1;
    cyc(0, 1, 0, 5'd13);
    after_edge();
    chk("requeue_cheia", 32'(fila_cheia_out), 32'd1);

    // Simultaneous refresh and disable: only the disable acts.
    cyc(0, 1, 1, 5'd7);
    after_edge();
    chk("both_des", 32'(desabilitar_out), 32'h2);
    chk("both_hab", 32'(habilitar_out),   32'h0);

    // Reset with a full queue.
    env_act = '0;
    cyc(1, 0, 0, 0);
    #1;
    chk("async_vazia", 32'(fila_vazia_out), 32'd1);
    chk("async_cheia", 32'(fila_cheia_out), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    after_edge();
    chk("post_reset_hab",  32'(habilitar_out), 32'h0);
    chk("post_reset_ocup", 32'(ocupados_out),  32'd0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (m_res[i] && !env_act[i] && $urandom_range(0, 3) == 0) env_act[i] = 1'b1;
        else if (env_act[i] && $urandom_range(0, 11) == 0) env_act[i] = 1'b0;
      end
      r = ($urandom_range(0, 249) == 0);
      a = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 7) == 0);
      cyc(r, a, d, AW'($urandom_range(0, 9)));
    end
    cyc(0, 0, 0, 0);
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gerenciador_ativos_fila.md
GERENCIADOR_ATIVOS_FILA -- requirements
Module: gerenciador_ativos_fila

Interface
REQ-001 SHALL have parameter NUM_NA, default 8, number of active nodes managed.
REQ-002 SHALL have parameter ADR_WIDTH, default 5, node address width.
REQ-003 SHALL have parameter FILA_DEPTH, default 4, pending-request FIFO depth (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port atualizar_in  input  1  activate/refresh request for endereco_in.
REQ-007 SHALL have port desativar_in  input  1  deactivate request for endereco_in.
REQ-008 SHALL have port endereco_in  input  ADR_WIDTH  request address.
REQ-009 SHALL have port na_endereco_in  input  ADR_WIDTH*NUM_NA  flat node addresses, node i at bits [ADR_WIDTH*i +: ADR_WIDTH].
REQ-010 SHALL have port na_ativo_in  input  NUM_NA  node i currently active.
REQ-011 SHALL have port habilitar_out  output  NUM_NA  one-hot, one-cycle enable pulse to a node.
REQ-012 SHALL have port desabilitar_out  output  NUM_NA  one-hot, one-cycle disable pulse to a node.
REQ-013 SHALL have port ocupados_out  output  $clog2(NUM_NA+1)  count of nodes active or reserved.
REQ-014 SHALL have port fila_vazia_out / fila_cheia_out  output  1 each  FIFO status.
REQ-015 SHALL have port descartado_out  output  1  one-cycle pulse: request dropped, FIFO full.

Function
REQ-016 All outputs SHALL be registered; response appears the cycle after the sampling edge (latency 1).
REQ-017 Hit: atualizar_in with endereco_in equal to an active node's address SHALL pulse habilitar_out of the lowest-index matching node (refresh), regardless of FIFO state.
REQ-018 Free node = !na_ativo_in[i] && !reserva[i]; reserva[i] SHALL set on grant to i and clear on the first cycle na_ativo_in[i]=1 or on desativar hitting i.
REQ-019 Miss with FIFO empty and a free node SHALL grant lowest-index free node: habilitar_out pulse, reserva set.
REQ-020 Miss with FIFO non-empty or no free node SHALL push endereco_in to FIFO tail (order preserved).
REQ-021 Miss with FIFO full and no pop in the same cycle SHALL drop the request and pulse descartado_out.
REQ-022 Push while full SHALL be accepted when a pop occurs in the same cycle; occupancy unchanged.
REQ-023 Drain: when FIFO non-empty, a free node exists and no hit grant this cycle, head SHALL be popped and granted to lowest-index free node.
REQ-024 At most one habilitar_out bit SHALL be set per cycle; priority: hit refresh > FIFO head > new miss.
REQ-025 A miss competing with a FIFO pop SHALL be pushed, never granted directly.
REQ-026 desativar_in matching an active or reserved node SHALL pulse desabilitar_out of lowest-index match and clear its reserva; no match: no effect.
REQ-027 atualizar_in and desativar_in both high SHALL execute desativar only; atualizar ignored, no push, no drop pulse.
REQ-028 desativar_in SHALL NOT remove FIFO entries.
REQ-029 ocupados_out SHALL equal popcount(na_ativo_in | reserva) registered.
REQ-030 FIFO pointers SHALL wrap modulo FILA_DEPTH; count width $clog2(FILA_DEPTH+1).

Reset
REQ-031 rst_n high SHALL immediately clear reserva, FIFO pointers/count, habilitar_out, desabilitar_out, descartado_out, ocupados_out, fila_cheia_out; fila_vazia_out SHALL be 1.
REQ-032 Reset mid-operation SHALL discard all pending FIFO entries and reservations; no pulse after release until a new request.

Verification (NUM_NA=4, ADR_WIDTH=5, FILA_DEPTH=2)
REQ-033 All nodes idle, atualizar 5 -> habilitar_out=0001 next cycle, ocupados_out=1; bench raises na_ativo_in[0], node0 addr 5.
REQ-034 Node0 active at 5, atualizar 5 -> habilitar_out=0001 refresh, ocupados_out unchanged, FIFO untouched.
REQ-035 Four nodes active, atualizar 9, 11, 13 -> 9,11 queued, fila_cheia_out=1, descartado_out pulse on 13.
REQ-036 Then na_ativo_in[2] falls -> next cycle habilitar_out=0100 with head 9 popped, fila_cheia_out=0; same-cycle atualizar 13 pushed behind 11.
REQ-037 Node1 active at 7, atualizar+desativar 7 same cycle -> desabilitar_out=0010 only, habilitar_out=0000.
REQ-038 FIFO holding 2 entries, rst_n pulse -> fila_vazia_out=1, ocupados_out=0, no habilitar_out pulse after release.
